daq_frame_packer: RTL and testbench

//  Consumes the decimated 24-bit sample stream from down_sample (tlast every LAST samples) and packs it

---
 rtl/daq_frame_packer.sv | 155 +++++++++++++++
 tb/tb_daq_frame_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_packer.sv
// Packs a 24-bit sample stream into 32-bit words, one {SYNC, seq} header word per frame.
// Latency: a sample's word is valid the cycle after its handshake; the header costs one stall cycle per frame.
// Backpressure: the output register holds while m_axis_tvalid && !m_axis_tready, and input ready drops with it.
module daq_frame_packer #(
    parameter logic [15:0] SYNC     = 16'hA55A,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] frame_seq,
    output logic        partial_pulse
);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  phase;       // number of samples of the current 4-sample group already consumed
    logic [23:0] residue;     // bytes of earlier samples not yet emitted, right-aligned

    logic        out_free;
    logic        accept;
    logic        hdr_load;
    logic        pack_has_word;
    logic [31:0] pack_word;
    logic [23:0] residue_nxt;
    logic [31:0] flush_word;
    logic [15:0] seq_nxt;

    // The output register may take a new word when empty or when its word leaves this cycle
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_PACK) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign hdr_load      = (state == ST_HDR) && s_axis_tvalid && out_free;

    // Combine the incoming sample with the held residue according to the group phase
    always_comb begin
        pack_has_word = 1'b1;
        pack_word     = '0;
        residue_nxt   = '0;
        case (phase)
            2'd0: begin
                pack_has_word = 1'b0;
                residue_nxt   = s_axis_tdata;
            end
            2'd1: begin
                pack_word   = {s_axis_tdata[7:0], residue[23:0]};
                residue_nxt = {8'h00, s_axis_tdata[23:8]};
            end
            2'd2: begin
                pack_word   = {s_axis_tdata[15:0], residue[15:0]};
                residue_nxt = {16'h0000, s_axis_tdata[23:16]};
            end
            default: begin
                pack_word   = {s_axis_tdata[23:0], residue[7:0]};
                residue_nxt = '0;
            end
        endcase
    end

    // Partial final word: residue right-aligned, unused upper bytes padded
    always_comb begin
        case (phase)
            2'd0:    flush_word = {PAD_BYTE, residue[23:0]};
            2'd1:    flush_word = {PAD_BYTE, PAD_BYTE, residue[15:0]};
            2'd2:    flush_word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, residue[7:0]};
            default: flush_word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, PAD_BYTE};
        endcase
    end

    // The sequence number advances each time a header is loaded, wrapping naturally at 16 bits
    always_comb begin
        seq_nxt = frame_seq;
        if (hdr_load) begin
            seq_nxt = frame_seq + 16'd1;
        end
    end

    // Frame FSM and registered output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_HDR;
            phase         <= 2'd0;
            residue       <= '0;
            frame_seq     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            partial_pulse <= 1'b0;
        end else begin
            frame_seq     <= seq_nxt;
            partial_pulse <= 1'b0;
            if (out_free) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state)
                ST_HDR: begin
                    if (hdr_load) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {SYNC, frame_seq};
                        m_axis_tlast  <= 1'b0;
                        state         <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (accept) begin
                        residue <= residue_nxt;
                        if (pack_has_word) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= pack_word;
                            m_axis_tlast  <= s_axis_tlast && (phase == 2'd3);
                        end
                        if (s_axis_tlast) begin
                            if (phase == 2'd3) begin
                                phase <= 2'd0;
                                state <= ST_HDR;
                            end else begin
                                // phase is kept so the flush knows how many residue bytes remain
                                state <= ST_FLUSH;
                            end
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= flush_word;
                        m_axis_tlast  <= 1'b1;
                        partial_pulse <= 1'b1;
                        phase         <= 2'd0;
                        residue       <= '0;
                        state         <= ST_HDR;
                    end
                end
                default: begin
                    state <= ST_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_daq_frame_packer.sv
// Bench for daq_frame_packer: byte-stream reference model, scoreboard of received words.
// Stimulus runs through tasks on core timing: inputs change 1ns after posedge, outputs sampled on negedge.
// Backpressure is exercised with random m_axis_tready and random s_axis_tvalid.
module tb_daq_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic [23:0] s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [15:0] frame_seq;
    logic        partial_pulse;

    always #5 clk = ~clk;

    daq_frame_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .frame_seq     (frame_seq),
        .partial_pulse (partial_pulse)
    );

    int errors = 0;
    int checks = 0;

    logic [23:0] smp_q[$];
    bit          lst_q[$];
    logic [32:0] exp_q[$];   // {tlast, tdata}
    logic [32:0] got_q[$];
    int          exp_partials;
    logic [15:0] exp_seq_end;

    int          pulse_cnt;
    int          pulse_run;
    int          pulse_max;
    int          stab_err;
    bit          hold_prev = 1'b0;
    logic [32:0] hold_val;

    // Output monitor: records accepted words, hold-stability violations and pulse widths
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
        if (hold_prev && (!m_tvalid || ({m_tlast, m_tdata} !== hold_val))) stab_err++;
        hold_prev = rst_n && m_tvalid && !m_tready;
        hold_val  = {m_tlast, m_tdata};
        if (partial_pulse === 1'b1) begin
            pulse_cnt++;
            pulse_run++;
            if (pulse_run > pulse_max) pulse_max = pulse_run;
        end else begin
            pulse_run = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: samples become a little-endian byte stream, cut into 4-byte words per frame
    task automatic build_model(input logic [15:0] seq0);
        logic [7:0]  bq[$];
        logic [15:0] seq;
        logic [23:0] s;
        logic [31:0] w;
        bit          start;
        seq = seq0;
        start = 1'b1;
        exp_q.delete();
        exp_partials = 0;
        for (int i = 0; i < smp_q.size(); i++) begin
            if (start) begin
                exp_q.push_back({1'b0, 16'hA55A, seq});
                seq = seq + 16'd1;
                start = 1'b0;
            end
            s = smp_q[i];
            for (int b = 0; b < 3; b++) bq.push_back(s[8*b +: 8]);
            if (bq.size() >= 4) begin
                w = {bq[3], bq[2], bq[1], bq[0]};
                repeat (4) void'(bq.pop_front());
                exp_q.push_back({(lst_q[i] && (bq.size() == 0)), w});
            end
            if (lst_q[i]) begin
                if (bq.size() > 0) begin
                    w = 32'h0000_0000;
                    for (int k = 0; k < bq.size(); k++) w[8*k +: 8] = bq[k];
                    exp_q.push_back({1'b1, w});
                    exp_partials++;
                    bq.delete();
                end
                start = 1'b1;
            end
        end
        exp_seq_end = seq;
    endtask

    function automatic int first_mismatch();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Drives smp_q/lst_q and drains until the expected word count arrives or the budget runs out
    task automatic run_stream(input bit rnd_v, input bit rnd_r, input int budget, output bit timed_out);
        int idx;
        int cyc;
        bit hs;
        bit pend;
        idx = 0;
        cyc = 0;
        pend = 1'b0;
        got_q.delete();
        pulse_cnt = 0;
        pulse_max = 0;
        pulse_run = 0;
        stab_err = 0;
        while ((idx < smp_q.size() || got_q.size() < exp_q.size()) && cyc < budget) begin
            if (idx < smp_q.size()) begin
                s_tvalid = pend || !rnd_v || ($urandom_range(0, 1) == 1);
                s_tdata  = smp_q[idx];
                s_tlast  = lst_q[idx];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = '0;
                s_tlast  = 1'b0;
            end
            m_tready = !rnd_r || ($urandom_range(0, 1) == 1);
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            pend = s_tvalid && !hs;
            cyc++;
        end
        timed_out = (cyc >= budget);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        checks++; if (frame_seq !== 16'h0) begin errors++; $display("FAIL reset_seq: got %h want 0", frame_seq); end
        checks++; if (partial_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", partial_pulse); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [32:0] want[4];
        bit to;
        want[0] = {1'b0, 32'hA55A_0000};
        want[1] = {1'b0, 32'h0200_0001};
        want[2] = {1'b0, 32'h0003_0000};
        want[3] = {1'b1, 32'h0000_0400};
        smp_q = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
        lst_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        build_model(16'h0000);
        run_stream(1'b0, 1'b0, 100, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got %0d words want 4", got_q.size()); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 33'h0, want[i]);
            end
        end
        checks++; if (frame_seq !== 16'h0001) begin errors++; $display("FAIL basic_seq: got %h want 0001", frame_seq); end
        checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL basic_pulse: got %0d want 0", pulse_cnt); end
    endtask

    task automatic test_full_frame();
        bit to;
        int mm;
        int nlast;
        smp_q.delete();
        lst_q.delete();
        for (int i = 0; i < 16000; i++) begin
            smp_q.push_back(24'($urandom));
            lst_q.push_back(i == 15999);
        end
        for (int i = 0; i < 4; i++) begin
            smp_q.push_back(24'($urandom));
            lst_q.push_back(i == 3);
        end
        build_model(frame_seq);
        run_stream(1'b0, 1'b0, 20000, to);
        mm = first_mismatch();
        nlast = 0;
        foreach (got_q[i]) if (got_q[i][32]) nlast++;
        checks++; if (to) begin errors++; $display("FAIL full_timeout: got %0d words", got_q.size()); end
        checks++; if (got_q.size() != 12005) begin errors++; $display("FAIL full_count: got %0d want 12005", got_q.size()); end
        checks++; if (mm != -1) begin errors++; $display("FAIL full_stream: first difference at word %0d of %0d/%0d", mm, got_q.size(), exp_q.size()); end
        checks++; if (nlast != 2) begin errors++; $display("FAIL full_tlast_count: got %0d want 2", nlast); end
        checks++;
        if (got_q.size() < 12002 || got_q[12000][32] !== 1'b1 || got_q[12001] !== {1'b0, 32'hA55A_0002}) begin
            errors++;
            $display("FAIL full_boundary: words 12000/12001 not tlast/header A55A0002");
        end
        checks++; if (frame_seq !== 16'h0003) begin errors++; $display("FAIL full_seq: got %h want 0003", frame_seq); end
    endtask

    task automatic test_partial();
        bit to;
        int mm;
        smp_q.delete();
        lst_q.delete();
        for (int i = 0; i < 4; i++) begin
            smp_q.push_back(24'($urandom));
            lst_q.push_back(1'b0);
        end
        smp_q.push_back(24'hABCDEF);
        lst_q.push_back(1'b1);
        build_model(frame_seq);
        run_stream(1'b0, 1'b0, 100, to);
        mm = first_mismatch();
        checks++; if (to || got_q.size() != 5) begin errors++; $display("FAIL partial_count: got %0d want 5", got_q.size()); end
        checks++; if (mm != -1) begin errors++; $display("FAIL partial_stream: first difference at word %0d", mm); end
        checks++;
        if (got_q.size() < 5 || got_q[4] !== {1'b1, 32'h00AB_CDEF}) begin
            errors++;
            $display("FAIL partial_flush: got %h want 100abcdef", (got_q.size() >= 5) ? got_q[4] : 33'h0);
        end
        checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL partial_pulse_cnt: got %0d want 1", pulse_cnt); end
        checks++; if (pulse_max != 1) begin errors++; $display("FAIL partial_pulse_width: got %0d want 1", pulse_max); end
    endtask

    task automatic test_random_bp();
        bit to;
        int mm;
        int len;
        smp_q.delete();
        lst_q.delete();
        for (int f = 0; f < 3; f++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                smp_q.push_back(24'($urandom));
                lst_q.push_back(i == len - 1);
            end
        end
        build_model(frame_seq);
        run_stream(1'b1, 1'b1, 2000, to);
        mm = first_mismatch();
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got %0d of %0d words", got_q.size(), exp_q.size()); end
        checks++; if (mm != -1) begin errors++; $display("FAIL bp_stream: first difference at word %0d of %0d/%0d", mm, got_q.size(), exp_q.size()); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stability: got %0d violations want 0", stab_err); end
        checks++; if (pulse_cnt != exp_partials) begin errors++; $display("FAIL bp_pulses: got %0d want %0d", pulse_cnt, exp_partials); end
        checks++; if (frame_seq !== exp_seq_end) begin errors++; $display("FAIL bp_seq: got %h want %h", frame_seq, exp_seq_end); end
    endtask

    task automatic test_seq_wrap();
        bit to;
        int mm;
        s_tvalid = 1'b0;
        @(negedge clk);
        force dut.frame_seq = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_seq;
        #1;
        checks++; if (frame_seq !== 16'hFFFF) begin errors++; $display("FAIL wrap_force: got %h want ffff", frame_seq); end
        smp_q = '{24'h123456, 24'h789ABC, 24'h0F0F0F, 24'hF0F0F0};
        lst_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        build_model(16'hFFFF);
        run_stream(1'b0, 1'b0, 100, to);
        mm = first_mismatch();
        checks++; if (to || mm != -1) begin errors++; $display("FAIL wrap_stream: first difference at word %0d of %0d", mm, got_q.size()); end
        checks++;
        if (got_q.size() < 4 || got_q[0] !== {1'b0, 32'hA55A_FFFF} || got_q[3] !== {1'b0, 32'hA55A_0000}) begin
            errors++;
            $display("FAIL wrap_headers: got %h/%h want 0a55affff/0a55a0000",
                     (got_q.size() > 0) ? got_q[0] : 33'h0, (got_q.size() > 3) ? got_q[3] : 33'h0);
        end
        checks++; if (frame_seq !== 16'h0001) begin errors++; $display("FAIL wrap_seq: got %h want 0001", frame_seq); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int mm;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = 24'hFFFFFF;
        repeat (4) @(posedge clk);   // header, then three samples leave a residue byte behind
        #1;
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_held: got tvalid %b want 1", m_tvalid); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", m_tvalid); end
        checks++; if (frame_seq !== 16'h0000) begin errors++; $display("FAIL mid_seq: got %h want 0000", frame_seq); end
        m_tready = 1'b1;
        smp_q = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
        lst_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        build_model(16'h0000);
        run_stream(1'b0, 1'b0, 100, to);
        mm = first_mismatch();
        checks++;
        if (got_q.size() < 2 || got_q[0] !== {1'b0, 32'hA55A_0000} || got_q[1] !== {1'b0, 32'h0200_0001}) begin
            errors++;
            $display("FAIL mid_restart: got %h/%h want 0a55a0000/002000001",
                     (got_q.size() > 0) ? got_q[0] : 33'h0, (got_q.size() > 1) ? got_q[1] : 33'h0);
        end
        checks++; if (to || mm != -1) begin errors++; $display("FAIL mid_stream: first difference at word %0d of %0d", mm, got_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        test_reset();
        test_basic();
        test_full_frame();
        test_partial();
        test_random_bp();
        test_seq_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
